// File: rtl/gpr_bank.sv
// General-purpose register bank on a shared tri-state data bus.
// Each register can be loaded from, asserted onto, or counted in place.
module gpr_bank #(
    parameter int                WIDTH     = 8,
    parameter int                NREGS     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int               SW        = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                    clk,
    input  logic                    resetBar,
    input  logic                    load_en,
    input  logic [SW-1:0]           load_sel,
    input  logic                    assert_en,
    input  logic [SW-1:0]           assert_sel,
    input  logic                    inc_en,
    input  logic                    dec_en,
    input  logic [SW-1:0]           cnt_sel,
    inout  wire  [WIDTH-1:0]        dbus,
    output logic [NREGS*WIDTH-1:0]  regs,
    output logic                    cnt_zero,
    output logic                    wrap
);

    localparam logic [SW:0] LIM = (SW+1)'(NREGS);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_cnt_zero;
    logic             r_wrap;

    logic             w_ld_ok;
    logic             w_as_ok;
    logic             w_cnt_ok;
    logic             w_cnt_wrap;
    logic [WIDTH-1:0] w_as_val;
    logic [WIDTH-1:0] w_cnt_old;
    logic [WIDTH-1:0] w_cnt_new;

    assign w_ld_ok = load_en && ({1'b0, load_sel} < LIM);
    assign w_as_ok = assert_en && ({1'b0, assert_sel} < LIM);

    // A load to the counted register wins, so the count is dropped.
    assign w_cnt_ok = (inc_en ^ dec_en)
                   && ({1'b0, cnt_sel} < LIM)
                   && !(w_ld_ok && (load_sel == cnt_sel));

    always_comb begin
        w_as_val  = '0;
        w_cnt_old = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (assert_sel == SW'(i)) w_as_val = r_regs[i];
            if (cnt_sel == SW'(i))    w_cnt_old = r_regs[i];
        end
    end

    assign w_cnt_new  = inc_en ? (w_cnt_old + WIDTH'(1))
                               : (w_cnt_old - WIDTH'(1));
    assign w_cnt_wrap = inc_en ? (&w_cnt_old) : (w_cnt_old == '0);

    assign dbus = w_as_ok ? w_as_val : {WIDTH{1'bz}};

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign cnt_zero = r_cnt_zero;
    assign wrap     = r_wrap;

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
            r_cnt_zero <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_ld_ok && (load_sel == SW'(i)))
                    r_regs[i] <= dbus;
                else if (w_cnt_ok && (cnt_sel == SW'(i)))
                    r_regs[i] <= w_cnt_new;
            end
            if (w_cnt_ok) begin
                r_cnt_zero <= (w_cnt_new == '0);
                r_wrap     <= w_cnt_wrap;
            end
        end
    end

endmodule

// File: tb/tb_gpr_bank.sv
// Scoreboard bench for gpr_bank: directed cases then random traffic,
// checked against an array model in separate monitor processes.
module tb_gpr_bank;

    localparam int N = 5;

    typedef struct packed {
        logic [N*8-1:0] regs;
        logic           cz;
        logic           wr;
    } exp_t;

    logic           clk = 1'b0;
    logic           resetBar = 1'b0;
    logic           load_en = 1'b0;
    logic [2:0]     load_sel = '0;
    logic           assert_en = 1'b0;
    logic [2:0]     assert_sel = '0;
    logic           inc_en = 1'b0;
    logic           dec_en = 1'b0;
    logic [2:0]     cnt_sel = '0;
    logic           tb_oe = 1'b1;
    logic [7:0]     tb_drv = '0;
    wire  [7:0]     dbus;
    logic [N*8-1:0] regs;
    logic           cnt_zero;
    logic           wrap;

    logic [7:0] m [8];
    logic       m_cz;
    logic       m_wr;
    exp_t       sq[$];
    logic [7:0] bq[$];
    int         n_pass = 0;
    int         n_total = 0;

    assign dbus = tb_oe ? tb_drv : 8'hzz;

    gpr_bank #(.WIDTH(8), .NREGS(N), .RESET_VAL(8'h00)) dut (
        .clk(clk), .resetBar(resetBar),
        .load_en(load_en), .load_sel(load_sel),
        .assert_en(assert_en), .assert_sel(assert_sel),
        .inc_en(inc_en), .dec_en(dec_en), .cnt_sel(cnt_sel),
        .dbus(dbus), .regs(regs), .cnt_zero(cnt_zero), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", nm, got, exp);
    endtask

    task automatic step(input logic rst, input logic ld,
                        input logic [2:0] ls, input logic ae,
                        input logic [2:0] as, input logic in,
                        input logic de, input logic [2:0] cs,
                        input logic [7:0] d);
        exp_t       e;
        logic [7:0] bv;
        logic [7:0] old;
        logic       drv;
        logic       ldok;
        logic       cok;
        @(negedge clk);
        drv = ae && (as < 3'(N));
        resetBar = rst; load_en = ld; load_sel = ls;
        assert_en = ae; assert_sel = as;
        inc_en = in; dec_en = de; cnt_sel = cs;
        tb_oe = !drv; tb_drv = d;
        if (drv) bv = m[as];
        else bv = d;
        bq.push_back(bv);
        if (!rst) begin
            for (int i = 0; i < 8; i++) m[i] = 8'h00;
            m_cz = 1'b0;
            m_wr = 1'b0;
        end else begin
            ldok = ld && (ls < 3'(N));
            cok = (in != de) && (cs < 3'(N)) && !(ldok && ls == cs);
            if (cok) begin
                old = m[cs];
                m[cs] = in ? old + 8'd1 : old - 8'd1;
                m_wr = in ? (old == 8'hFF) : (old == 8'h00);
                m_cz = (m[cs] == 8'h00);
            end
            if (ldok) m[ls] = bv;
        end
        e.regs = {m[4], m[3], m[2], m[1], m[0]};
        e.cz = m_cz;
        e.wr = m_wr;
        sq.push_back(e);
    endtask

    // Bus is combinational: sample it mid-cycle, before the edge.
    initial forever begin
        @(negedge clk);
        #2;
        if (bq.size() > 0) check("dbus", 64'(dbus), 64'(bq.pop_front()));
    end

    initial forever begin : state_mon
        exp_t e;
        @(posedge clk);
        #1;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            check("regs", 64'(regs), 64'(e.regs));
            check("cnt_zero", 64'(cnt_zero), 64'(e.cz));
            check("wrap", 64'(wrap), 64'(e.wr));
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        m_cz = 1'b0;
        m_wr = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 8'h5A);
        step(0, 1, 1, 0, 0, 1, 0, 2, 8'h77);
        step(1, 0, 0, 1, 2, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 2, 0, 0, 0, 8'h00);
        step(1, 1, 1, 0, 0, 0, 0, 0, 8'hA5);
        step(1, 0, 0, 1, 1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 1, 1, 0, 0, 0, 8'h00);
        step(1, 1, 3, 0, 0, 0, 0, 0, 8'hFF);
        step(1, 0, 0, 0, 0, 1, 0, 3, 8'h00);
        step(1, 0, 0, 0, 0, 0, 1, 3, 8'h00);
        step(1, 1, 0, 0, 0, 0, 0, 0, 8'h10);
        step(1, 1, 0, 0, 0, 1, 0, 0, 8'h33);
        step(1, 0, 0, 0, 0, 1, 1, 0, 8'h00);
        step(1, 1, 2, 0, 0, 1, 0, 4, 8'h3C);
        step(1, 1, 5, 1, 6, 1, 0, 7, 8'h00);
        step(1, 1, 7, 1, 5, 0, 1, 5, 8'h00);
        step(0, 1, 2, 0, 0, 1, 0, 1, 8'hEE);
        step(1, 0, 0, 1, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                 1'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                 8'($urandom));
        end
        repeat (4) @(posedge clk);
        #3;
        if (sq.size() != 0 || bq.size() != 0) begin
            n_total++;
            $display("FAIL drain got %0d/%0d pending expected 0/0",
                     sq.size(), bq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
GPR_BANK -- requirements
Module: gpr_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and of dbus.
REQ-002 Parameter NREGS, default 4, number of registers (2..16).
REQ-003 Parameter RESET_VAL, default 0, value loaded into every register on reset.
REQ-004 SW = max(1, clog2(NREGS)) is the width of every select port.
REQ-005 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 Port resetBar  input  1  synchronous active-low reset.
REQ-007 Port load_en  input  1  load register load_sel from dbus this edge.
REQ-008 Port load_sel  input  SW  index of register to load.
REQ-009 Port assert_en  input  1  drive register assert_sel onto dbus.
REQ-010 Port assert_sel  input  SW  index of register to drive.
REQ-011 Port inc_en  input  1  increment register cnt_sel this edge.
REQ-012 Port dec_en  input  1  decrement register cnt_sel this edge.
REQ-013 Port cnt_sel  input  SW  index of register to count.
REQ-014 Port dbus  inout  WIDTH  shared data bus.
REQ-015 Port regs  output  NREGS*WIDTH  all register contents; register i at bits [i*WIDTH +: WIDTH].
REQ-016 Port cnt_zero  output  1  registered flag: last counted register became 0.
REQ-017 Port wrap  output  1  registered flag: last count wrapped (inc from all-ones, dec from 0).

Function
REQ-018 dbus driven combinationally with register assert_sel when assert_en=1 and assert_sel<NREGS; otherwise all WIDTH bits high-impedance.
REQ-019 Driven dbus value is the pre-edge register content; a load or count on the same edge is not visible until after that edge.
REQ-020 On rising clk with load_en=1 and load_sel<NREGS, register load_sel takes the dbus value; load latency one edge.
REQ-021 Load and assert on the same register, same cycle: register keeps its value (bus self-loop); no X propagation.
REQ-022 inc_en=1 (dec_en=0), cnt_sel<NREGS: register cnt_sel becomes (value+1) mod 2^WIDTH.
REQ-023 dec_en=1 (inc_en=0), cnt_sel<NREGS: register cnt_sel becomes (value-1) mod 2^WIDTH.
REQ-024 inc_en=1 and dec_en=1 together: no count; cnt_zero and wrap hold their values.
REQ-025 Load and count targeting the same register on the same edge: load wins; count suppressed; cnt_zero and wrap hold.
REQ-026 Load and count on different registers, same edge: both take effect.
REQ-027 Out-of-range select (>= NREGS) on any port: that operation is ignored; no register changes; bus not driven.
REQ-028 On each effective count, cnt_zero is set to (new value == 0) and wrap is set per REQ-017 on the same edge; both hold otherwise.
REQ-029 Registers not targeted by an effective load or count hold their value.

Reset
REQ-030 On rising clk with resetBar=0, all registers become RESET_VAL; cnt_zero=0; wrap=0; all loads and counts that edge are ignored.
REQ-031 REQ-018 applies to dbus during reset; after reset, regs reflects RESET_VAL from the following cycle.
REQ-032 Reset asserted mid-sequence: reset takes priority over any load or count on that edge; no partial update.

Verification
REQ-033 Reset, then assert_en=1, assert_sel=2 -> dbus=0x00 and regs all 0x00; assert_en=0 -> dbus all Z.
REQ-034 Drive dbus=0xA5, load_en=1, load_sel=1 for one edge -> regs[1]=0xA5, others unchanged; next cycle assert_sel=1 -> dbus=0xA5.
REQ-035 regs[3]=0xFF, inc_en=1, cnt_sel=3 -> regs[3]=0x00, cnt_zero=1, wrap=1; dec once more -> 0xFF, cnt_zero=0, wrap=1.
REQ-036 regs[0]=0x10; same edge load_sel=0 with dbus=0x33 and inc_en=1, cnt_sel=0 -> regs[0]=0x33, flags unchanged; separately inc_en=dec_en=1 -> no change.
REQ-037 NREGS=3: load_sel=3, assert_sel=3, cnt_sel=3 -> no register changes, dbus Z; resetBar=0 concurrent with load_en=1 -> all registers RESET_VAL.
